// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// State encoding is fixed so it stays readable on a debug probe.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int DEF_RST_PULSE_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT       = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES = 256;
    localparam int DEF_MAX_RETRIES        = 3;
    localparam int DEF_CNT_W              = 16;

    // Saturating increment for the retry counter.
    function automatic logic [1:0] sat_inc(input logic [1:0] value, input logic [1:0] limit);
        return (value >= limit) ? limit : value + 2'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a signal arriving asynchronously to clk.
// Both stages clear to 0 on reset, so the output reads as "not asserted".
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments let both stages sample their inputs
    // from before the edge; blocking would collapse the chain to one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL rst input, qualifies lock and releases sys_rst only after
// lock has been stable; retries on lock timeout and parks in FAIL after too many.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES   = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_lost,
    output logic       failed,
    output logic [1:0] retry_count
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             lk;
    logic             rst_done, lock_timeout_hit, stable_done;
    logic [1:0]       retry_inc;
    logic             pll_rst_d, sys_rst_d, lock_lost_d, failed_d;
    logic [1:0]       retry_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    assign rst_done         = (cnt == RST_LAST);
    assign lock_timeout_hit = (cnt == TIMEOUT_LAST);
    assign stable_done      = (cnt == STABLE_LAST);
    assign retry_inc        = sat_inc(retry_count, RETRY_MAX);

    // State, shared counter and all outputs are registered together.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            lock_lost   <= 1'b0;
            failed      <= 1'b0;
            retry_count <= 2'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pll_rst     <= pll_rst_d;
            sys_rst     <= sys_rst_d;
            lock_lost   <= lock_lost_d;
            failed      <= failed_d;
            retry_count <= retry_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        if (restart) begin
            state_d = ST_RESET;
        end else begin
            case (state)
                ST_RESET:     if (rst_done) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lk)
                        state_d = ST_STABLE;
                    else if (lock_timeout_hit)
                        state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
                end
                ST_STABLE: begin
                    if (!lk)
                        state_d = ST_WAIT_LOCK;
                    else if (stable_done)
                        state_d = ST_RUN;
                end
                // Stay one extra RUN cycle so lock_lost leads sys_rst by a cycle.
                ST_RUN:       if (lock_lost) state_d = ST_RESET;
                ST_FAIL:      state_d = ST_FAIL;
                default:      state_d = ST_RESET;
            endcase
        end

        // Counter only advances in timed states so it cannot wrap in RUN/FAIL.
        if (restart || (state_d != state))
            cnt_d = '0;
        else if (state inside {ST_RESET, ST_WAIT_LOCK, ST_STABLE})
            cnt_d = cnt + CNT_W'(1);
        else
            cnt_d = cnt;
    end

    always_comb begin
        pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
        sys_rst_d   = (state_d != ST_RUN);
        failed_d    = (state_d == ST_FAIL);
        lock_lost_d = !restart && (state == ST_RUN) && !lock_lost && !lk;

        retry_d = retry_count;
        if (restart)
            retry_d = 2'd0;
        else if ((state == ST_WAIT_LOCK) && !lk && lock_timeout_hit)
            retry_d = retry_inc;
        else if ((state == ST_STABLE) && (state_d == ST_RUN))
            retry_d = 2'd0;
        else if ((state == ST_RUN) && (state_d == ST_RESET))
            retry_d = 2'd0;
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Cycle n is sampled at the falling edge after n rising edges since rst release.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_lost;
    logic       failed;
    logic [1:0] retry_count;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT       (20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .lock_lost   (lock_lost),
        .failed      (failed),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of test, expected finish before 50000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv();
        @(negedge refclk);
        cyc++;
    endtask

    task automatic adv_to(input int c);
        while (cyc < c) adv();
    endtask

    // Holds rst for a few cycles, checks the reset values, releases at a falling edge.
    task automatic apply_reset();
        rst        = 1'b1;
        restart    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check("rst_pll_rst",   32'(pll_rst),     32'd1);
        check("rst_sys_rst",   32'(sys_rst),     32'd1);
        check("rst_lock_lost", 32'(lock_lost),   32'd0);
        check("rst_failed",    32'(failed),      32'd0);
        check("rst_retry",     32'(retry_count), 32'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst        = 1'b1;
        restart    = 1'b0;
        pll_locked = 1'b0;

        // Nominal lock: pll_locked high from cycle 10, RUN reached at cycle 20.
        apply_reset();
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) adv();
            check("nom_pll_rst",   32'(pll_rst),   32'(cyc < 4));
            check("nom_sys_rst",   32'(sys_rst),   32'(cyc < 20));
            check("nom_lock_lost", 32'(lock_lost), 32'd0);
            if (cyc == 9) pll_locked = 1'b1;
        end
        check("nom_retry",  32'(retry_count), 32'd0);
        check("nom_failed", 32'(failed),      32'd0);

        // Loss of lock in RUN: drop from cycle 26, pulse at 28, RESET 29-32, relock to RUN at 42.
        for (int c = 23; c <= 44; c++) begin
            adv();
            check("lol_lock_lost", 32'(lock_lost), 32'(cyc == 28));
            check("lol_sys_rst",   32'(sys_rst),   32'((cyc >= 29) && (cyc < 42)));
            check("lol_pll_rst",   32'(pll_rst),   32'((cyc >= 29) && (cyc <= 32)));
            check("lol_retry",     32'(retry_count), 32'd0);
            if (cyc == 25) pll_locked = 1'b0;
            if (cyc == 30) pll_locked = 1'b1;
        end

        // Timeout/retry/fail with no lock, then restart out of FAIL at cycle 56.
        apply_reset();
        for (int c = 0; c <= 55; c++) begin
            if (c > 0) adv();
            check("to_sys_rst", 32'(sys_rst), 32'd1);
            check("to_pll_rst", 32'(pll_rst),
                  32'((cyc < 4) || ((cyc >= 24) && (cyc < 28)) || (cyc >= 48)));
            check("to_failed",  32'(failed),  32'(cyc >= 48));
            check("to_retry",   32'(retry_count), (cyc < 24) ? 32'd0 : (cyc < 48) ? 32'd1 : 32'd2);
        end
        restart = 1'b1;
        adv();
        restart = 1'b0;
        check("rs_fail_failed",  32'(failed),      32'd0);
        check("rs_fail_retry",   32'(retry_count), 32'd0);
        check("rs_fail_pll_rst", 32'(pll_rst),     32'd1);
        check("rs_fail_sys_rst", 32'(sys_rst),     32'd1);

        // Restart coinciding with the timeout that would otherwise enter FAIL.
        adv_to(80);
        check("rs_retry1",    32'(retry_count), 32'd1);
        check("rs_pll_rst80", 32'(pll_rst),     32'd1);
        adv_to(103);
        check("rs_pre_pll_rst", 32'(pll_rst), 32'd0);
        check("rs_pre_retry",   32'(retry_count), 32'd1);
        restart = 1'b1;
        adv();
        restart = 1'b0;
        check("rs_to_failed",  32'(failed),      32'd0);
        check("rs_to_retry",   32'(retry_count), 32'd0);
        check("rs_to_pll_rst", 32'(pll_rst),     32'd1);
        adv_to(107);
        check("rs_to_pll_rst107", 32'(pll_rst), 32'd1);
        adv();
        check("rs_to_pll_rst108", 32'(pll_rst), 32'd0);
        check("rs_to_failed108",  32'(failed),  32'd0);

        // Stability glitch: pll_locked low for cycle 16 only, RUN delayed to cycle 27.
        apply_reset();
        for (int c = 0; c <= 28; c++) begin
            if (c > 0) adv();
            check("gl_lock_lost", 32'(lock_lost), 32'd0);
            check("gl_sys_rst",   32'(sys_rst),   32'(cyc < 27));
            check("gl_pll_rst",   32'(pll_rst),   32'(cyc < 4));
            check("gl_retry",     32'(retry_count), 32'd0);
            if (cyc == 9)  pll_locked = 1'b1;
            if (cyc == 15) pll_locked = 1'b0;
            if (cyc == 16) pll_locked = 1'b1;
        end

        // Asynchronous reset mid-STABLE, checked before the next rising edge.
        apply_reset();
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) adv();
            if (cyc == 9) pll_locked = 1'b1;
        end
        check("ar_pre_pll_rst", 32'(pll_rst), 32'd0);
        check("ar_pre_sys_rst", 32'(sys_rst), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_pll_rst", 32'(pll_rst), 32'd1);
        check("ar_sys_rst", 32'(sys_rst), 32'd1);
        check("ar_failed",  32'(failed),  32'd0);
        @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) adv();
            check("ar_seq_pll_rst", 32'(pll_rst), 32'(cyc < 4));
            check("ar_seq_sys_rst", 32'(sys_rst), 32'(cyc < 13));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
